spike_out_arbiter: RTL

- Round-robin scheduler that shares the single spike-output word register between NUM_REQ neuron cores.
- Accepts spike words from requesters through valid/ready handshakes.
- Sequences one external write per grant into the spike-output register.
- Defers writes while the host bus is accessing that register, and enforces a programmable quiet gap so the host can sample each word.

---
 rtl/spike_arb_pkg.sv | 18 +
 rtl/spike_out_arbiter_rr_pick.sv | 36 +++
 rtl/spike_out_arbiter.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/spike_arb_pkg.sv
// Shared types and helpers for the spike-output arbiter.
// Optional build macro: SPIKE_OR_MERGE_EN (see spike_out_arbiter).
package spike_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_GAP   = 2'd2
    } spike_state_e;

    localparam int GAP_W = 4;

    // Width of a requester index; never narrower than one bit.
    function automatic int id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/spike_out_arbiter_rr_pick.sv
// Combinational round-robin selector: first valid index at or after ptr,
// wrapping modulo NUM_REQ.
module rr_pick
    import spike_arb_pkg::*;
#(
    parameter  int NUM_REQ = 4,
    localparam int ID_W    = id_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] valid,
    input  logic [ID_W-1:0]    ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [ID_W-1:0]    idx,
    output logic               found
);

    int pos;

    always_comb begin
        grant = '0;
        idx   = '0;
        found = 1'b0;
        pos   = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            pos = int'(ptr) + i;
            if (pos >= NUM_REQ) begin
                pos = pos - NUM_REQ;
            end
            if (!found && valid[pos]) begin
                found      = 1'b1;
                grant[pos] = 1'b1;
                idx        = ID_W'(pos);
            end
        end
    end

endmodule

// File: rtl/spike_out_arbiter.sv
// Round-robin scheduler sharing the spike-output register between neuron cores.
// Define SPIKE_OR_MERGE_EN to accept all valid requesters at once and OR their words.
module spike_out_arbiter
    import spike_arb_pkg::*;
#(
    parameter  int NUM_REQ    = 4,
    parameter  int DATA_W     = 32,
    parameter  int GAP_CYCLES = 1,
    localparam int ID_W       = id_width(NUM_REQ)
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    input  logic [NUM_REQ-1:0]          req_valid_i,
    input  logic [NUM_REQ*DATA_W-1:0]   req_data_i,
    output logic [NUM_REQ-1:0]          req_ready_o,
    input  logic                        host_busy_i,
    output logic [DATA_W-1:0]           spike_data_o,
    output logic                        spike_we_o,
    output logic [ID_W-1:0]             grant_id_o,
    output logic                        busy_o,
    output spike_state_e                state_o
);

    // Handshake: a word moves from requester k when req_valid_i[k] and
    // req_ready_o[k] are both high at a rising edge; valid/data stay stable until then.

    spike_state_e        state_q, state_d;
    logic [ID_W-1:0]     ptr_q, ptr_d;
    logic [GAP_W-1:0]    gap_q, gap_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic [ID_W-1:0]     grant_q, grant_d;

    logic [NUM_REQ-1:0]  sel_ready;
    logic [ID_W-1:0]     sel_idx;
    logic [DATA_W-1:0]   sel_data;
    logic                accept;

`ifdef SPIKE_OR_MERGE_EN
    logic [NUM_REQ-1:0]  low_grant;
    logic                low_found;

    rr_pick #(.NUM_REQ(NUM_REQ)) u_low_pick (
        .valid (req_valid_i),
        .ptr   ('0),
        .grant (low_grant),
        .idx   (sel_idx),
        .found (low_found)
    );

    assign sel_ready = req_valid_i;
`else
    logic                pick_found;

    rr_pick #(.NUM_REQ(NUM_REQ)) u_rr_pick (
        .valid (req_valid_i),
        .ptr   (ptr_q),
        .grant (sel_ready),
        .idx   (sel_idx),
        .found (pick_found)
    );
`endif

    // With one-hot selection this is a plain mux; with merging it ORs all accepted words.
    always_comb begin
        sel_data = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (sel_ready[k]) begin
                sel_data = sel_data | req_data_i[k*DATA_W +: DATA_W];
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
            gap_q   <= '0;
            data_q  <= '0;
            grant_q <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            gap_q   <= gap_d;
            data_q  <= data_d;
            grant_q <= grant_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        gap_d   = gap_q;
        data_d  = data_q;
        grant_d = grant_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    data_d  = sel_data;
                    grant_d = sel_idx;
                    state_d = ST_WRITE;
                end
            end
            ST_WRITE: begin
`ifndef SPIKE_OR_MERGE_EN
                ptr_d = (grant_q == ID_W'(NUM_REQ - 1)) ? '0 : grant_q + 1'b1;
`endif
                if (GAP_CYCLES == 0) begin
                    gap_d   = '0;
                    state_d = ST_IDLE;
                end else begin
                    gap_d   = GAP_W'(GAP_CYCLES);
                    state_d = ST_GAP;
                end
            end
            ST_GAP: begin
                if (gap_q <= GAP_W'(1)) begin
                    gap_d   = '0;
                    state_d = ST_IDLE;
                end else begin
                    gap_d = gap_q - 1'b1;
                end
            end
            default: begin
                gap_d   = '0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // Ready is gated by reset so nothing is offered while the registers are held.
    always_comb begin
        req_ready_o = '0;
        if (state_q == ST_IDLE && rst_ni && !host_busy_i) begin
            req_ready_o = sel_ready;
        end
        accept       = |req_ready_o;
        spike_we_o   = (state_q == ST_WRITE);
        busy_o       = (state_q != ST_IDLE);
        spike_data_o = data_q;
        grant_id_o   = grant_q;
        state_o      = state_q;
    end

endmodule
